hazard_fwd_unit: RTL and testbench

Parametrised operand-forwarding and hazard unit for the rv32im pipeline. It replaces the fixed three-source EXE/MEM/WB bypass with N ordered forwarding sources, and adds load-use stall detection. It also keeps a register scoreboard for long-latency MUL/DIV writebacks, with an outstanding-op limit and a stall-cycle performance counter. It sits between decode and execute and drives the ID-stage hold.

---
 rtl/hazard_fwd_unit_pkg.sv | 18 +
 rtl/hazard_fwd_unit_fwd_src_select.sv | 53 +++++
 rtl/hazard_fwd_unit.sv | 127 ++++++++++++
 tb/tb_hazard_fwd_unit.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_fwd_unit_pkg.sv
// Shared constants for the operand-forwarding / hazard unit:
// datapath width, register-address width and register count.
package hazard_fwd_unit_pkg;

   localparam int DEF_XLEN = 32;
   localparam int REG_AW   = 5;
   localparam int NUM_REGS = 32;

   // One-hot decode of a register address; x0 never gets a bit.
   function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_AW-1:0] addr);
      logic [NUM_REGS-1:0] mask;
      mask       = '0;
      mask[addr] = 1'b1;
      mask[0]    = 1'b0;
      return mask;
   endfunction

endpackage

// File: rtl/hazard_fwd_unit_fwd_src_select.sv
// Per-operand forwarding mux: priority search over NSRC bypass sources
// (index 0 youngest), then the long-latency writeback bypass, then the
// register file. Reports a raw hazard, not yet qualified by operand use.
module fwd_src_select
   import hazard_fwd_unit_pkg::*;
#(
   parameter int XLEN = DEF_XLEN,
   parameter int NSRC = 3
) (
   input  logic [REG_AW-1:0]      addr,
   input  logic [XLEN-1:0]        rf_data,
   input  logic [NSRC*REG_AW-1:0] src_rdaddr,
   input  logic [NSRC*XLEN-1:0]   src_rddata,
   input  logic [NSRC-1:0]        src_rdwe,
   input  logic [NSRC-1:0]        src_ready,
   input  logic                   long_done,
   input  logic [REG_AW-1:0]      long_rd,
   input  logic [XLEN-1:0]        long_data,
   input  logic                   busy_bit,
   output logic [XLEN-1:0]        data_o,
   output logic                   hazard_o
);

   logic found;

   // Youngest matching source wins; a match that is not ready is a hazard
   // even if an older source or the long writeback could supply the value.
   always_comb begin
      data_o   = rf_data;
      hazard_o = 1'b0;
      found    = 1'b0;
      if (addr != '0) begin
         for (int k = 0; k < NSRC; k++) begin
            if (!found && src_rdwe[k] && (src_rdaddr[k*REG_AW +: REG_AW] == addr)) begin
               found = 1'b1;
               if (src_ready[k]) begin
                  data_o = src_rddata[k*XLEN +: XLEN];
               end else begin
                  hazard_o = 1'b1;
               end
            end
         end
         if (!found) begin
            if (long_done && (long_rd == addr)) begin
               data_o = long_data;
            end else if (busy_bit) begin
               hazard_o = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Operand forwarding, load-use / long-latency hazard detection and the
// MUL/DIV register scoreboard. Sits between decode and execute.
//
// Handshake: decode presents an instruction with id_valid_i; it is consumed
// (issued) in a cycle where id_valid_i=1, stall_o=0 and flush_i=0. While
// stall_o=1 decode must hold the instruction unchanged.
module hazard_fwd_unit
   import hazard_fwd_unit_pkg::*;
#(
   parameter int XLEN     = DEF_XLEN,
   parameter int NSRC     = 3,
   parameter int MAX_LONG = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   id_valid_i,
   input  logic [REG_AW-1:0]      rs1_addr_i,
   input  logic [REG_AW-1:0]      rs2_addr_i,
   input  logic                   rs1_used_i,
   input  logic                   rs2_used_i,
   input  logic [XLEN-1:0]        rs1_data_i,
   input  logic [XLEN-1:0]        rs2_data_i,
   input  logic [REG_AW-1:0]      id_rd_i,
   input  logic                   id_rdwe_i,
   input  logic                   id_long_i,
   input  logic                   flush_i,
   input  logic [NSRC*REG_AW-1:0] src_rdaddr_i,
   input  logic [NSRC*XLEN-1:0]   src_rddata_i,
   input  logic [NSRC-1:0]        src_rdwe_i,
   input  logic [NSRC-1:0]        src_ready_i,
   input  logic                   long_done_i,
   input  logic [REG_AW-1:0]      long_rd_i,
   input  logic [XLEN-1:0]        long_data_i,
   output logic [XLEN-1:0]        rs1_data_o,
   output logic [XLEN-1:0]        rs2_data_o,
   output logic                   stall_o,
   output logic [NUM_REGS-1:0]    busy_o,
   output logic [3:0]             long_cnt_o,
   output logic [31:0]            stall_cycles_o
);

   logic [NUM_REGS-1:0] busy;
   logic [3:0]          long_cnt;
   logic [31:0]         stall_cycles;

   logic rs1_hazard, rs2_hazard;
   logic waw_stall, struct_stall;
   logic issue, long_issue, long_retire;
   logic [NUM_REGS-1:0] set_mask, clr_mask;

   fwd_src_select #(.XLEN(XLEN), .NSRC(NSRC)) u_sel_rs1 (
      .addr       (rs1_addr_i),
      .rf_data    (rs1_data_i),
      .src_rdaddr (src_rdaddr_i),
      .src_rddata (src_rddata_i),
      .src_rdwe   (src_rdwe_i),
      .src_ready  (src_ready_i),
      .long_done  (long_done_i),
      .long_rd    (long_rd_i),
      .long_data  (long_data_i),
      .busy_bit   (busy[rs1_addr_i]),
      .data_o     (rs1_data_o),
      .hazard_o   (rs1_hazard)
   );

   fwd_src_select #(.XLEN(XLEN), .NSRC(NSRC)) u_sel_rs2 (
      .addr       (rs2_addr_i),
      .rf_data    (rs2_data_i),
      .src_rdaddr (src_rdaddr_i),
      .src_rddata (src_rddata_i),
      .src_rdwe   (src_rdwe_i),
      .src_ready  (src_ready_i),
      .long_done  (long_done_i),
      .long_rd    (long_rd_i),
      .long_data  (long_data_i),
      .busy_bit   (busy[rs2_addr_i]),
      .data_o     (rs2_data_o),
      .hazard_o   (rs2_hazard)
   );

   // Stall causes, issue qualification and scoreboard set/clear masks.
   always_comb begin
      // A writeback to the same rd in this cycle frees the slot for the new writer.
      waw_stall    = id_rdwe_i && (id_rd_i != '0) && busy[id_rd_i] &&
                     !(long_done_i && (long_rd_i == id_rd_i));
      struct_stall = id_long_i && (long_cnt == 4'(MAX_LONG)) && !long_done_i;
      stall_o      = id_valid_i && ((rs1_used_i && rs1_hazard) ||
                                    (rs2_used_i && rs2_hazard) ||
                                    waw_stall || struct_stall);
      issue        = id_valid_i && !stall_o && !flush_i;
      long_issue   = issue && id_long_i && id_rdwe_i && (id_rd_i != '0);
      // Only a writeback for a tracked register retires a count; stray ones
      // just clear (an already-clear) bit.
      long_retire  = long_done_i && busy[long_rd_i] && (long_cnt != 4'd0);
      set_mask     = long_issue  ? reg_onehot(id_rd_i)   : '0;
      clr_mask     = long_done_i ? reg_onehot(long_rd_i) : '0;
   end

   // Scoreboard bits and outstanding count; set beats clear on one register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy     <= '0;
         long_cnt <= '0;
      end else begin
         busy <= (busy & ~clr_mask) | set_mask;
         if (long_issue && !long_retire && (long_cnt != 4'hF)) begin
            long_cnt <= long_cnt + 4'd1;
         end else if (!long_issue && long_retire) begin
            long_cnt <= long_cnt - 4'd1;
         end
      end
   end

   // Saturating count of cycles with stall_o asserted.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cycles <= '0;
      end else if (stall_o && (stall_cycles != 32'hFFFF_FFFF)) begin
         stall_cycles <= stall_cycles + 32'd1;
      end
   end

   assign busy_o         = {busy[NUM_REGS-1:1], 1'b0};
   assign long_cnt_o     = long_cnt;
   assign stall_cycles_o = stall_cycles;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit: expected values are queued when a step
// is driven and popped when the matching DUT output is sampled.
module tb_hazard_fwd_unit;

   localparam int XLEN = 32;
   localparam int NSRC = 3;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 id_valid_i;
   logic [4:0]           rs1_addr_i, rs2_addr_i;
   logic                 rs1_used_i, rs2_used_i;
   logic [XLEN-1:0]      rs1_data_i, rs2_data_i;
   logic [4:0]           id_rd_i;
   logic                 id_rdwe_i, id_long_i, flush_i;
   logic [NSRC*5-1:0]    src_rdaddr_i;
   logic [NSRC*XLEN-1:0] src_rddata_i;
   logic [NSRC-1:0]      src_rdwe_i, src_ready_i;
   logic                 long_done_i;
   logic [4:0]           long_rd_i;
   logic [XLEN-1:0]      long_data_i;
   logic [XLEN-1:0]      rs1_data_o, rs2_data_o;
   logic                 stall_o;
   logic [31:0]          busy_o;
   logic [3:0]           long_cnt_o;
   logic [31:0]          stall_cycles_o;

   logic [31:0] exp_q[$];
   string       tag_q[$];
   int          checks   = 0;
   int          failures = 0;

   hazard_fwd_unit #(.XLEN(XLEN), .NSRC(NSRC), .MAX_LONG(4)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .id_valid_i     (id_valid_i),
      .rs1_addr_i     (rs1_addr_i),
      .rs2_addr_i     (rs2_addr_i),
      .rs1_used_i     (rs1_used_i),
      .rs2_used_i     (rs2_used_i),
      .rs1_data_i     (rs1_data_i),
      .rs2_data_i     (rs2_data_i),
      .id_rd_i        (id_rd_i),
      .id_rdwe_i      (id_rdwe_i),
      .id_long_i      (id_long_i),
      .flush_i        (flush_i),
      .src_rdaddr_i   (src_rdaddr_i),
      .src_rddata_i   (src_rddata_i),
      .src_rdwe_i     (src_rdwe_i),
      .src_ready_i    (src_ready_i),
      .long_done_i    (long_done_i),
      .long_rd_i      (long_rd_i),
      .long_data_i    (long_data_i),
      .rs1_data_o     (rs1_data_o),
      .rs2_data_o     (rs2_data_o),
      .stall_o        (stall_o),
      .busy_o         (busy_o),
      .long_cnt_o     (long_cnt_o),
      .stall_cycles_o (stall_cycles_o)
   );

   // Clock: 10 ns period.
   always #5 clk = ~clk;

   task automatic idle();
      id_valid_i   = 1'b0;
      rs1_addr_i   = '0;
      rs2_addr_i   = '0;
      rs1_used_i   = 1'b0;
      rs2_used_i   = 1'b0;
      rs1_data_i   = 32'hA1A1_0001;
      rs2_data_i   = 32'hB2B2_0002;
      id_rd_i      = '0;
      id_rdwe_i    = 1'b0;
      id_long_i    = 1'b0;
      flush_i      = 1'b0;
      src_rdaddr_i = '0;
      src_rddata_i = '0;
      src_rdwe_i   = '0;
      src_ready_i  = '0;
      long_done_i  = 1'b0;
      long_rd_i    = '0;
      long_data_i  = '0;
   endtask

   task automatic set_src(input int k, input logic [4:0] rd, input logic [31:0] d,
                          input logic we, input logic rdy);
      src_rdaddr_i[k*5 +: 5]       = rd;
      src_rddata_i[k*XLEN +: XLEN] = d;
      src_rdwe_i[k]                = we;
      src_ready_i[k]               = rdy;
   endtask

   // Decode instruction presented this cycle.
   task automatic id_instr(input logic [4:0] rd, input logic rdwe, input logic lng);
      id_valid_i = 1'b1;
      id_rd_i    = rd;
      id_rdwe_i  = rdwe;
      id_long_i  = lng;
   endtask

   // Advance one clock edge; return at the following falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic expect_val(input string tag, input logic [31:0] v);
      exp_q.push_back(v);
      tag_q.push_back(tag);
   endtask

   task automatic check(input logic [31:0] obs);
      logic [31:0] exp_v;
      string       tag;
      if (exp_q.size() == 0) begin
         failures++;
         $error("FAIL scoreboard_underrun observed=%h", obs);
      end else begin
         exp_v = exp_q.pop_front();
         tag   = tag_q.pop_front();
         checks++;
         assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      step();
      step();

      // Reset state (still in reset: stall_o follows the cleared state).
      expect_val("reset_busy", 32'h0);         check(busy_o);
      expect_val("reset_cnt", 32'h0);          check(32'(long_cnt_o));
      expect_val("reset_stall_cycles", 32'h0); check(stall_cycles_o);
      expect_val("reset_stall", 32'h0);        check(32'(stall_o));
      rst_n = 1'b1;
      step();

      // Forwarding priority: youngest matching source wins.
      idle();
      id_instr(5'd0, 1'b0, 1'b0);
      set_src(0, 5'd5, 32'h11, 1'b1, 1'b1);
      set_src(1, 5'd5, 32'h22, 1'b1, 1'b1);
      set_src(2, 5'd5, 32'h33, 1'b1, 1'b1);
      rs1_addr_i = 5'd5; rs1_used_i = 1'b1;
      rs2_addr_i = 5'd3; rs2_used_i = 1'b1; rs2_data_i = 32'hABC;
      #1;
      expect_val("fwd_src0", 32'h11);    check(rs1_data_o);
      expect_val("fwd_no_stall", 32'h0); check(32'(stall_o));
      expect_val("fwd_rs2_rf", 32'hABC); check(rs2_data_o);
      src_rdwe_i[0] = 1'b0;
      #1;
      expect_val("fwd_src1", 32'h22);    check(rs1_data_o);
      src_rdwe_i[1] = 1'b0;
      #1;
      expect_val("fwd_src2", 32'h33);    check(rs1_data_o);
      step();

      // Load-use on rs2 via a not-ready source 0.
      idle();
      id_instr(5'd0, 1'b0, 1'b0);
      set_src(0, 5'd7, 32'h77, 1'b1, 1'b0);
      rs2_addr_i = 5'd7; rs2_used_i = 1'b1;
      #1;
      expect_val("load_use_stall", 32'h1); check(32'(stall_o));
      step();
      expect_val("stall_cnt_1", 32'h1);    check(stall_cycles_o);
      rs2_used_i = 1'b0;
      #1;
      expect_val("unused_no_stall", 32'h0); check(32'(stall_o));
      step();
      expect_val("stall_cnt_hold", 32'h1);  check(stall_cycles_o);

      // x0 always returns register-file data, even with a matching source.
      idle();
      id_instr(5'd0, 1'b0, 1'b0);
      set_src(0, 5'd0, 32'h99, 1'b1, 1'b0);
      rs1_addr_i = 5'd0; rs1_used_i = 1'b1; rs1_data_i = 32'h1234;
      #1;
      expect_val("x0_data", 32'h1234); check(rs1_data_o);
      expect_val("x0_no_stall", 32'h0); check(32'(stall_o));
      step();

      // MUL to x9, dependent read stalls until the long writeback.
      idle();
      id_instr(5'd9, 1'b1, 1'b1);
      #1;
      expect_val("mul_issue_no_stall", 32'h0); check(32'(stall_o));
      step();
      idle();
      id_instr(5'd0, 1'b0, 1'b0);
      rs1_addr_i = 5'd9; rs1_used_i = 1'b1;
      #1;
      expect_val("mul_busy", 32'h0000_0200); check(busy_o);
      expect_val("mul_cnt", 32'h1);          check(32'(long_cnt_o));
      expect_val("mul_dep_stall", 32'h1);    check(32'(stall_o));
      step();
      long_done_i = 1'b1; long_rd_i = 5'd9; long_data_i = 32'hDEAD;
      #1;
      expect_val("long_bypass", 32'hDEAD); check(rs1_data_o);
      expect_val("long_release", 32'h0);   check(32'(stall_o));
      step();
      idle();
      #1;
      expect_val("mul_busy_clear", 32'h0);  check(busy_o);
      expect_val("mul_cnt_clear", 32'h0);   check(32'(long_cnt_o));
      expect_val("stall_cnt_2", 32'h2);     check(stall_cycles_o);

      // Fill the four long-op slots with DIVs to x1..x4.
      for (int i = 1; i <= 4; i++) begin
         idle();
         id_instr(5'(i), 1'b1, 1'b1);
         step();
      end
      idle();
      #1;
      expect_val("div_cnt_full", 32'h4);       check(32'(long_cnt_o));
      expect_val("div_busy", 32'h0000_001E);   check(busy_o);
      id_instr(5'd10, 1'b1, 1'b1);
      #1;
      expect_val("struct_stall", 32'h1);       check(32'(stall_o));
      long_done_i = 1'b1; long_rd_i = 5'd1; long_data_i = 32'h1;
      #1;
      expect_val("struct_release", 32'h0);     check(32'(stall_o));
      step();
      idle();
      #1;
      expect_val("swap_cnt", 32'h4);           check(32'(long_cnt_o));
      expect_val("swap_busy", 32'h0000_041C);  check(busy_o);

      // Retire x2, then issue a long op to x6.
      long_done_i = 1'b1; long_rd_i = 5'd2;
      step();
      idle();
      id_instr(5'd6, 1'b1, 1'b1);
      step();
      idle();
      #1;
      expect_val("x6_busy", 32'h0000_0458);    check(busy_o);
      expect_val("x6_cnt", 32'h4);             check(32'(long_cnt_o));

      // Re-issue to x6 in the same cycle its writeback completes: set wins.
      id_instr(5'd6, 1'b1, 1'b1);
      long_done_i = 1'b1; long_rd_i = 5'd6; long_data_i = 32'h66;
      #1;
      expect_val("reissue_no_stall", 32'h0);   check(32'(stall_o));
      step();
      idle();
      #1;
      expect_val("reissue_busy", 32'h0000_0458); check(busy_o);
      expect_val("reissue_cnt", 32'h4);           check(32'(long_cnt_o));

      // Short op writing busy x6: WAW stall.
      id_instr(5'd6, 1'b1, 1'b0);
      #1;
      expect_val("waw_stall", 32'h1);          check(32'(stall_o));
      step();
      expect_val("stall_cnt_3", 32'h3);        check(stall_cycles_o);

      // Flush does not touch the scoreboard.
      idle();
      flush_i = 1'b1;
      step();
      expect_val("flush_keeps_cnt", 32'h4);    check(32'(long_cnt_o));

      // Reset with entries pending drops everything.
      idle();
      rst_n = 1'b0;
      step();
      expect_val("rst_busy", 32'h0);           check(busy_o);
      expect_val("rst_cnt", 32'h0);            check(32'(long_cnt_o));
      expect_val("rst_stall_cycles", 32'h0);   check(stall_cycles_o);
      rst_n = 1'b1;

      // Stray writeback with nothing outstanding: no underflow.
      long_done_i = 1'b1; long_rd_i = 5'd12;
      step();
      idle();
      #1;
      expect_val("no_underflow", 32'h0);       check(32'(long_cnt_o));
      expect_val("stray_busy", 32'h0);         check(busy_o);

      if (exp_q.size() != 0) begin
         failures++;
         $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Hard time limit so the run always terminates.
   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
